// File: rtl/szg_i2s2_pmod_tx_pkg.sv
// Shared I2S constants, sample types and slot-bit helpers.
// The I2S2 receive path uses the same definitions.
package szg_i2s2_pmod_tx_pkg;

   localparam int I2S_SLOT_BITS   = 32;
   localparam int I2S_SAMPLE_BITS = 24;
   localparam int I2S_SLOT_IDX_W  = $clog2(I2S_SLOT_BITS);
   localparam int I2S_FRAME_SCLKS = 2 * I2S_SLOT_BITS;

   typedef logic [I2S_SAMPLE_BITS-1:0] i2s_sample_t;
   typedef logic [I2S_SLOT_IDX_W-1:0]  i2s_slot_idx_t;

   typedef struct packed {
      i2s_sample_t left;
      i2s_sample_t right;
   } i2s_pair_t;

   // Frame counter width: one SCLK period is 2*SCLK_HALF clocks.
   function automatic int i2s_cnt_width(input int sclk_half);
      return $clog2(sclk_half) + 1 + $clog2(I2S_FRAME_SCLKS);
   endfunction

   // Slot 0 is the one-bit I2S delay, slots 1..24 carry MSB..LSB, the rest pad with 0.
   function automatic logic i2s_slot_bit(input i2s_sample_t word, input i2s_slot_idx_t n);
      i2s_slot_idx_t idx;
      idx = I2S_SLOT_IDX_W'(I2S_SAMPLE_BITS) - n;
      if ((n != '0) && (n <= I2S_SLOT_IDX_W'(I2S_SAMPLE_BITS))) begin
         return word[idx];
      end
      return 1'b0;
   endfunction

endpackage

// File: rtl/szg_i2s2_pmod_tx_if.sv
// Sample handshake and I2S pin bundle for the I2S2 PMOD transmitter.
interface szg_i2s2_pmod_tx_if;
   import szg_i2s2_pmod_tx_pkg::*;

   i2s_sample_t sample_left;
   i2s_sample_t sample_right;
   logic        sample_valid;
   logic        sample_ready;
   logic        frame_start;
   logic        underrun;
   logic        tx_mclk;
   logic        tx_sclk;
   logic        tx_lrck;
   logic        tx_sdout;

   modport master (
      output sample_left, sample_right, sample_valid,
      input  sample_ready, frame_start, underrun,
      input  tx_mclk, tx_sclk, tx_lrck, tx_sdout
   );

   modport slave (
      input  sample_left, sample_right, sample_valid,
      output sample_ready, frame_start, underrun,
      output tx_mclk, tx_sclk, tx_lrck, tx_sdout
   );

endinterface

// File: rtl/szg_i2s2_clkgen.sv
// Free-running frame counter producing MCLK/SCLK/LRCK, slot index and frame-end strobe.
// Clock outputs are registered; slot index, channel select and strobe are the raw count.
module szg_i2s2_clkgen
   import szg_i2s2_pmod_tx_pkg::*;
#(
   parameter int SCLK_HALF = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   output logic          o_mclk,
   output logic          o_sclk,
   output logic          o_lrck,
   output i2s_slot_idx_t o_slot_idx,
   output logic          o_lr_sel,
   output logic          o_frame_end
);

   localparam int S     = $clog2(SCLK_HALF);
   localparam int CNT_W = i2s_cnt_width(SCLK_HALF);

   logic [CNT_W-1:0] r_cnt;
   logic             r_mclk;
   logic             r_sclk;
   logic             r_lrck;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_mclk <= 1'b0;
         r_sclk <= 1'b0;
         r_lrck <= 1'b0;
      end else begin
         r_cnt  <= r_cnt + CNT_W'(1);
         r_mclk <= r_cnt[S-2];
         r_sclk <= r_cnt[S];
         r_lrck <= r_cnt[CNT_W-1];
      end
   end

   assign o_mclk      = r_mclk;
   assign o_sclk      = r_sclk;
   assign o_lrck      = r_lrck;
   assign o_slot_idx  = r_cnt[S+1 +: I2S_SLOT_IDX_W];
   assign o_lr_sel    = r_cnt[CNT_W-1];
   assign o_frame_end = &r_cnt;

endmodule

// File: rtl/szg_i2s2_pmod_tx.sv
// I2S transmitter for the I2S2 PMOD line-out: valid/ready sample intake,
// one-deep holding register, per-frame active register and serial bit mux.
module szg_i2s2_pmod_tx
   import szg_i2s2_pmod_tx_pkg::*;
#(
   parameter int SCLK_HALF = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   szg_i2s2_pmod_tx_if.slave   bus
);

   logic          w_mclk;
   logic          w_sclk;
   logic          w_lrck;
   logic          w_lr_sel;
   logic          w_frame_end;
   i2s_slot_idx_t w_slot_idx;
   logic          w_accept;
   logic          w_full_nxt;
   i2s_sample_t   w_word;

   i2s_pair_t     r_hold;
   i2s_pair_t     r_active;
   logic          r_full;
   logic          r_ready;
   logic          r_frame_start;
   logic          r_underrun;
   logic          r_sdout;

   szg_i2s2_clkgen #(
      .SCLK_HALF (SCLK_HALF)
   ) u_clkgen (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .o_mclk      (w_mclk),
      .o_sclk      (w_sclk),
      .o_lrck      (w_lrck),
      .o_slot_idx  (w_slot_idx),
      .o_lr_sel    (w_lr_sel),
      .o_frame_end (w_frame_end)
   );

   assign w_accept = bus.sample_valid & r_ready;

   // Ready is registered from the next full state so a second beat is never taken
   // in the cycle right after an accept; an accept at an empty boundary refills.
   assign w_full_nxt = w_accept | (r_full & ~w_frame_end);

   assign w_word = w_lr_sel ? r_active.right : r_active.left;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hold        <= '0;
         r_active      <= '0;
         r_full        <= 1'b0;
         r_ready       <= 1'b0;
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;
         r_sdout       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_hold <= '{left: bus.sample_left, right: bus.sample_right};
         end
         if (w_frame_end && r_full) begin
            r_active <= r_hold;
         end
         r_full        <= w_full_nxt;
         r_ready       <= ~w_full_nxt;
         r_frame_start <= w_frame_end;
         r_underrun    <= w_frame_end & ~r_full;
         r_sdout       <= i2s_slot_bit(w_word, w_slot_idx);
      end
   end

   assign bus.sample_ready = r_ready;
   assign bus.frame_start  = r_frame_start;
   assign bus.underrun     = r_underrun;
   assign bus.tx_mclk      = w_mclk;
   assign bus.tx_sclk      = w_sclk;
   assign bus.tx_lrck      = w_lrck;
   assign bus.tx_sdout     = r_sdout;

endmodule

// File: tb/tb_szg_i2s2_pmod_tx.sv
// Directed bench for szg_i2s2_pmod_tx at SCLK_HALF=4 (512-cycle frames) with an
// I2S capture model that rebuilds each 32-bit slot from tx_sdout on rising tx_sclk.
module tb_szg_i2s2_pmod_tx;
   import szg_i2s2_pmod_tx_pkg::*;

   localparam int SCLK_HALF = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;
   int   n_fs = 0;
   int   n_ur = 0;

   logic [32:0] q_slot[$];
   i2s_pair_t   exp_q[$];
   logic [31:0] m_slot = '0;
   int          m_cnt = 0;
   logic        m_prev_lr = 1'b0;

   szg_i2s2_pmod_tx_if bus ();

   szg_i2s2_pmod_tx #(
      .SCLK_HALF (SCLK_HALF)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.frame_start) n_fs++;
         if (bus.underrun)    n_ur++;
      end
   end

   // A partial slot cut by reset is dropped, as is anything not exactly 32 bits long.
   always @(posedge bus.tx_sclk or posedge rst) begin
      if (rst) begin
         m_cnt     = 0;
         m_slot    = '0;
         m_prev_lr = 1'b0;
      end else begin
         if (bus.tx_lrck != m_prev_lr) begin
            if (m_cnt == I2S_SLOT_BITS) q_slot.push_back({m_prev_lr, m_slot});
            m_cnt     = 0;
            m_prev_lr = bus.tx_lrck;
         end
         m_slot = {m_slot[30:0], bus.tx_sdout};
         m_cnt++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic expect_slot(input string tag, input logic ch, input i2s_sample_t w);
      logic [32:0] s;
      int          t;
      t = 0;
      while (q_slot.size() == 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_avail"}, 64'(q_slot.size() != 0), 64'(1));
      s = (q_slot.size() != 0) ? q_slot.pop_front() : '0;
      check(tag, 64'(s), 64'({ch, 1'b0, w, 7'b0}));
   endtask

   function automatic logic [6:0] outvec();
      return {bus.sample_ready, bus.frame_start, bus.underrun,
              bus.tx_mclk, bus.tx_sclk, bus.tx_lrck, bus.tx_sdout};
   endfunction

   function automatic i2s_pair_t pat(input int i);
      i2s_pair_t p;
      p.left  = 24'h100000 + 24'(i);
      p.right = 24'hF00000 + 24'(i);
      return p;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] v, pv;
      int         r1[3], r2[3], hi[3];
      int         idx, n_acc, n_rdy_hi, fs0, ur0, t;
      logic       rdy_prev, acc;
      i2s_pair_t  p;

      bus.sample_valid = 1'b0;
      bus.sample_left  = '0;
      bus.sample_right = '0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_outputs", 64'(outvec()), 64'(0));
      rst = 1'b0;
      #1 check("rdy_at_release", 64'(bus.sample_ready), 64'(0));
      wait_cyc(1);
      check("rdy_first_edge", 64'(bus.sample_ready), 64'(1));
      bus.sample_left  = 24'hA5C3F0;
      bus.sample_right = 24'h123456;
      bus.sample_valid = 1'b1;
      wait_cyc(2);
      bus.sample_valid = 1'b0;
      check("rdy_after_acc", 64'(bus.sample_ready), 64'(0));

      // Clock shape plus spot checks around the first two frame boundaries.
      for (int k = 0; k < 3; k++) begin
         r1[k] = -1; r2[k] = -1; hi[k] = 0;
      end
      pv = {bus.tx_lrck, bus.tx_sclk, bus.tx_mclk};
      while (cyc < 1100) begin
         @(negedge clk);
         v = {bus.tx_lrck, bus.tx_sclk, bus.tx_mclk};
         for (int k = 0; k < 3; k++) begin
            if (v[k] && !pv[k]) begin
               if (r1[k] < 0)      r1[k] = cyc;
               else if (r2[k] < 0) r2[k] = cyc;
            end
            if (r1[k] >= 0 && r2[k] < 0 && v[k]) hi[k]++;
         end
         pv = v;
         case (cyc)
            511: begin
               check("rdy_before_bnd1", 64'(bus.sample_ready), 64'(0));
               check("fs_before_bnd1", 64'(bus.frame_start), 64'(0));
            end
            512: begin
               check("fs_bnd1", 64'(bus.frame_start), 64'(1));
               check("ur_bnd1", 64'(bus.underrun), 64'(0));
               check("rdy_after_bnd1", 64'(bus.sample_ready), 64'(1));
               check("lrck_at_bnd1", 64'(bus.tx_lrck), 64'(1));
            end
            513: begin
               check("fs_width", 64'(bus.frame_start), 64'(0));
               check("lrck_fall", 64'(bus.tx_lrck), 64'(0));
            end
            520: check("sd_delay_bit", 64'(bus.tx_sdout), 64'(0));
            521: check("sd_left_msb", 64'(bus.tx_sdout), 64'(1));
            529: check("sd_left_b22", 64'(bus.tx_sdout), 64'(0));
            1024: begin
               check("ur_bnd2", 64'(bus.underrun), 64'(1));
               check("fs_bnd2", 64'(bus.frame_start), 64'(1));
            end
            1025: check("ur_width", 64'(bus.underrun), 64'(0));
            default: ;
         endcase
      end
      check("mclk_period", 64'(r2[0] - r1[0]), 64'(2));
      check("mclk_high",   64'(hi[0]),         64'(1));
      check("sclk_period", 64'(r2[1] - r1[1]), 64'(8));
      check("sclk_high",   64'(hi[1]),         64'(4));
      check("lrck_period", 64'(r2[2] - r1[2]), 64'(512));
      check("lrck_high",   64'(hi[2]),         64'(256));

      expect_slot("f0_l", 1'b0, 24'h000000);
      expect_slot("f0_r", 1'b1, 24'h000000);
      expect_slot("f1_l", 1'b0, 24'hA5C3F0);
      expect_slot("f1_r", 1'b1, 24'h123456);
      wait_cyc(1600);
      expect_slot("f2_l", 1'b0, 24'hA5C3F0);
      expect_slot("f2_r", 1'b1, 24'h123456);
      check("fs_count_3", 64'(n_fs), 64'(3));
      check("ur_count_2", 64'(n_ur), 64'(2));

      // Streaming: valid held high, data advances on every observed handshake.
      idx = 0;
      p = pat(0);
      bus.sample_left  = p.left;
      bus.sample_right = p.right;
      bus.sample_valid = 1'b1;
      rdy_prev = bus.sample_ready;
      n_acc = 0; n_rdy_hi = 0; fs0 = n_fs; ur0 = n_ur;
      while (cyc < 4160) begin
         @(negedge clk);
         if (rdy_prev) begin
            exp_q.push_back(pat(idx));
            n_acc++;
            idx++;
            p = pat(idx);
            bus.sample_left  = p.left;
            bus.sample_right = p.right;
         end
         rdy_prev = bus.sample_ready;
         if (bus.sample_ready) n_rdy_hi++;
      end
      check("stream_accepts", 64'(n_acc), 64'(6));
      check("stream_rdy_hi",  64'(n_rdy_hi), 64'(5));
      check("stream_no_ur",   64'(n_ur - ur0), 64'(0));
      check("stream_fs",      64'(n_fs - fs0), 64'(5));

      // Full-scale pair queued behind the last streamed one.
      bus.sample_left  = 24'h800000;
      bus.sample_right = 24'h7FFFFF;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 1000) begin
         @(negedge clk);
         t++;
         if (rdy_prev) acc = 1'b1;
         rdy_prev = bus.sample_ready;
      end
      bus.sample_valid = 1'b0;
      check("fullscale_accepted", 64'(acc), 64'(1));
      check("fullscale_acc_cyc", 64'(cyc), 64'(4609));
      wait_cyc(5632);
      check("ur_repeat_fs", 64'(bus.underrun), 64'(1));
      wait_cyc(5640);
      bus.sample_left  = 24'h111111;
      bus.sample_right = 24'h222222;
      bus.sample_valid = 1'b1;
      wait_cyc(5641);
      bus.sample_valid = 1'b0;
      check("rdy_after_acc2", 64'(bus.sample_ready), 64'(0));

      // Reset in the middle of the right slot; the held 111111/222222 pair is dropped.
      wait_cyc(5988);
      check("lrck_before_rst", 64'(bus.tx_lrck), 64'(1));
      #2 rst = 1'b1;
      #1 check("rst_async", 64'(outvec()), 64'(0));
      repeat (3) @(negedge clk);
      check("rst_hold", 64'(outvec()), 64'(0));
      rst = 1'b0;
      wait_cyc(1);
      check("rdy_after_rst2", 64'(bus.sample_ready), 64'(1));
      wait_cyc(512);
      check("fs_after_rst", 64'(bus.frame_start), 64'(1));
      check("ur_after_rst", 64'(bus.underrun), 64'(1));
      wait_cyc(800);

      expect_slot("f3_l", 1'b0, 24'hA5C3F0);
      expect_slot("f3_r", 1'b1, 24'h123456);
      for (int i = 0; i < 6; i++) begin
         expect_slot($sformatf("f%0d_l", i + 4), 1'b0, exp_q[i].left);
         expect_slot($sformatf("f%0d_r", i + 4), 1'b1, exp_q[i].right);
      end
      expect_slot("f10_l", 1'b0, 24'h800000);
      expect_slot("f10_r", 1'b1, 24'h7FFFFF);
      expect_slot("f11_l", 1'b0, 24'h800000);
      expect_slot("pr0_l", 1'b0, 24'h000000);
      expect_slot("pr0_r", 1'b1, 24'h000000);
      expect_slot("pr1_l", 1'b0, 24'h000000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
